// File: rtl/seg7_capture_if.sv
// seg7_capture_if: segment-capture bus bundling the sampled pattern, the digit handshake and the status flags.
// master drives seg_in/digit_ready and observes results; slave is the capture block.
interface seg7_capture_if;
  logic [6:0] seg_in;
  logic       digit_ready;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       err_illegal;
  logic       overrun;
  logic [7:0] err_count;
  modport master (
    output seg_in, digit_ready,
    input  digit, digit_valid, blank, err_illegal, overrun, err_count
  );
  modport slave (
    input  seg_in, digit_ready,
    output digit, digit_valid, blank, err_illegal, overrun, err_count
  );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: debounces an active-low 7-segment pattern, decodes qualified hex digits and delivers them over a valid/ready handshake.
// Ports: clk (rising edge), reset (sync, active-high), bus (slave): seg_in/digit_ready in; digit, digit_valid, blank, err_illegal, overrun, err_count out.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input logic          clk,
  input logic          reset,
  seg7_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] MAX = CW'(STABLE_CYCLES);
  logic [6:0]    seg_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    digit_q, digit_d, dec;
  logic          valid_q, valid_d, blank_q, blank_d, err_q, err_d, ovr_q, ovr_d;
  logic [7:0]    ecnt_q, ecnt_d;
  logic          same, qual, legal;
  always_comb begin
    legal = 1'b1;
    dec   = 4'h0;
    case (seg_q)
      7'h40: dec = 4'h0;
      7'h79: dec = 4'h1;
      7'h24: dec = 4'h2;
      7'h30: dec = 4'h3;
      7'h19: dec = 4'h4;
      7'h12: dec = 4'h5;
      7'h02: dec = 4'h6;
      7'h78: dec = 4'h7;
      7'h00: dec = 4'h8;
      7'h10: dec = 4'h9;
      7'h08: dec = 4'hA;
      7'h03: dec = 4'hB;
      7'h46: dec = 4'hC;
      7'h21: dec = 4'hD;
      7'h06: dec = 4'hE;
      7'h0E: dec = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  // The qualify fires only on the single edge where the run length reaches MAX.
  always_comb begin
    same    = bus.seg_in == seg_q;
    cnt_d   = !same ? '0 : (cnt_q == MAX ? cnt_q : cnt_q + 1'b1);
    qual    = same && cnt_q == MAX - 1'b1;
    digit_d = digit_q;
    valid_d = valid_q && !bus.digit_ready;
    blank_d = blank_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    ecnt_d  = ecnt_q;
    if (qual) begin
      if (seg_q == 7'h7F) begin
        blank_d = 1'b1;
      end else if (legal) begin
        blank_d = 1'b0;
        if (valid_q && !bus.digit_ready) begin
          ovr_d = 1'b1;
        end else begin
          digit_d = dec;
          valid_d = 1'b1;
        end
      end else begin
        blank_d = 1'b0;
        err_d   = 1'b1;
        ecnt_d  = ecnt_q == 8'hFF ? ecnt_q : ecnt_q + 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q   <= 7'h7F;
      cnt_q   <= '0;
      digit_q <= 4'h0;
      valid_q <= 1'b0;
      blank_q <= 1'b1;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ecnt_q  <= 8'h00;
    end else begin
      seg_q   <= bus.seg_in;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      ecnt_q  <= ecnt_d;
    end
  end
  assign bus.digit       = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.blank       = blank_q;
  assign bus.err_illegal = err_q;
  assign bus.overrun     = ovr_q;
  assign bus.err_count   = ecnt_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: vector table, corner-case sequences and randomized run against a run-history reference model.
module tb_seg7_capture;
  localparam int S = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  seg7_capture_if bus();
  seg7_capture #(.STABLE_CYCLES(S)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  int pass = 0, total = 0;
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] hist [$];
  logic [3:0] m_digit = 0;
  logic m_valid = 0, m_blank = 1, m_err = 0, m_ovr = 0;
  int m_ecnt = 0;
  // Model: a pattern qualifies when the last S+1 samples (reset counts as a 7F sample) agree and the sample before them differs.
  function automatic void model_edge(input logic r, input logic [6:0] s, input logic rd);
    int n, idx;
    logic q;
    if (r) begin
      m_digit = 0; m_valid = 0; m_blank = 1; m_err = 0; m_ovr = 0; m_ecnt = 0;
      hist.delete();
      hist.push_back(7'h7F);
      return;
    end
    hist.push_back(s);
    if (hist.size() > S + 2) void'(hist.pop_front());
    n = hist.size();
    q = n >= S + 1;
    if (q) for (int i = n - S - 1; i < n; i++) if (hist[i] != s) q = 0;
    if (n == S + 2 && hist[0] == s) q = 0;
    idx = -1;
    for (int i = 0; i < 16; i++) if (pat[i] == s) idx = i;
    if (m_valid && rd) m_valid = 0;
    if (q) begin
      if (s == 7'h7F) m_blank = 1;
      else if (idx >= 0) begin
        m_blank = 0;
        if (m_valid) m_ovr = 1;
        else begin m_digit = 4'(idx); m_valid = 1; end
      end else begin
        m_blank = 0; m_err = 1;
        if (m_ecnt < 255) m_ecnt++;
      end
    end
  endfunction
  task automatic step(input logic r, input logic [6:0] s, input logic rd);
    reset = r; bus.seg_in = s; bus.digit_ready = rd;
    @(posedge clk);
    model_edge(r, s, rd);
    #1;
  endtask
  task automatic hold(input logic [6:0] s, input int n, input logic rd);
    for (int i = 0; i < n; i++) step(1'b0, s, rd);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [31:0] outs();
    return 32'({bus.digit, bus.digit_valid, bus.blank, bus.err_illegal, bus.overrun, bus.err_count});
  endfunction
  function automatic logic [31:0] mouts();
    return 32'({m_digit, m_valid, m_blank, m_err, m_ovr, 8'(m_ecnt)});
  endfunction
  typedef struct {logic r; logic [6:0] s; logic rd; logic [3:0] d; logic v; logic b;} vec_t;
  vec_t tbl [17];
  initial begin
    tbl = '{'{1'b1, 7'h7F, 1'b1, 4'h0, 1'b0, 1'b1},
            '{1'b0, 7'h24, 1'b1, 4'h0, 1'b0, 1'b1},
            '{1'b0, 7'h24, 1'b1, 4'h0, 1'b0, 1'b1},
            '{1'b0, 7'h24, 1'b1, 4'h0, 1'b0, 1'b1},
            '{1'b0, 7'h24, 1'b1, 4'h0, 1'b0, 1'b1},
            '{1'b0, 7'h24, 1'b1, 4'h2, 1'b1, 1'b0},
            '{1'b0, 7'h24, 1'b1, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h00, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h3, 1'b1, 1'b0},
            '{1'b0, 7'h30, 1'b0, 4'h3, 1'b1, 1'b0}};
    bus.seg_in = 7'h7F;
    bus.digit_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].rd);
      chk($sformatf("vec%0d", i), 32'({bus.digit, bus.digit_valid, bus.blank}), 32'({tbl[i].d, tbl[i].v, tbl[i].b}));
    end
    chk("vec_err_clean", 32'({bus.err_illegal, bus.overrun, bus.err_count}), 32'd0);
    step(1'b1, 7'h7F, 1'b0);
    hold(7'h7F, 6, 1'b0);
    chk("reset_blank_idle", outs(), 32'({4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    step(1'b1, 7'h7F, 1'b0);
    hold(7'h79, 5, 1'b0);
    hold(7'h24, 5, 1'b0);
    chk("overrun_keep", outs(), 32'({4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00}));
    step(1'b1, 7'h7F, 1'b0);
    hold(7'h79, 5, 1'b0);
    hold(7'h24, 4, 1'b0);
    step(1'b0, 7'h24, 1'b1);
    chk("ready_replace", outs(), 32'({4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    step(1'b1, 7'h7F, 1'b0);
    for (int i = 0; i < 300; i++) begin
      hold(7'h55, 5, 1'b0);
      if (i < 4) chk("illegal_blank0", 32'(bus.blank), 32'd0);
      hold(7'h7F, 5, 1'b0);
      if (i < 4) chk("illegal_blank1", 32'(bus.blank), 32'd1);
    end
    chk("illegal_sat", outs(), 32'({4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF}));
    step(1'b1, 7'h7F, 1'b0);
    hold(7'h24, 5, 1'b0);
    chk("abort_pre", 32'({bus.digit, bus.digit_valid}), 32'({4'h2, 1'b1}));
    hold(7'h79, 4, 1'b0);
    step(1'b1, 7'h79, 1'b1);
    chk("abort_reset", outs(), 32'({4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    hold(7'h79, 4, 1'b0);
    chk("abort_noqual", outs(), 32'({4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    step(1'b0, 7'h79, 1'b0);
    chk("abort_requal", 32'({bus.digit, bus.digit_valid}), 32'({4'h1, 1'b1}));
    step(1'b1, 7'h7F, 1'b0);
    for (int k = 0; k < 500; k++) begin
      int sel, len;
      logic [6:0] s;
      sel = $urandom_range(0, 9);
      s = sel < 6 ? pat[$urandom_range(0, 15)] : sel < 8 ? 7'h7F : 7'($urandom);
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        step($urandom_range(0, 149) == 0, s, $urandom_range(0, 2) == 0);
        chk("random", outs(), mouts());
      end
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
